wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 5, register index width.
REQ-002 Parameter: DATA_WIDTH, 32, register data width.
REQ-003 Parameter: LSU_DEPTH, 2, LSU result buffer entries (power of two, >=2).
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 alu_valid / alu_ready  input / output  1 / 1  ALU result handshake.
REQ-007 alu_rd / alu_data  input  ADDR_WIDTH / DATA_WIDTH  ALU destination index and result.
REQ-008 lsu_valid / lsu_ready  input / output  1 / 1  load result handshake.
REQ-009 lsu_rd / lsu_data  input  ADDR_WIDTH / DATA_WIDTH  load destination index and data.
REQ-010 wen / rd / wdata  output  1 / ADDR_WIDTH / DATA_WIDTH  register-file write port, registered.
REQ-011 wb_count  output  32  count of committed writes with wen=1.

Function
REQ-012 Transfer on a source occurs when valid && ready in the same cycle; at most one register write is committed per cycle.
REQ-013 LSU transfers enter a FIFO of LSU_DEPTH entries; lsu_ready = !fifo_full; the FIFO head is the LSU candidate.
REQ-014 Arbiter candidates: ALU input (alu_valid) and FIFO head (fifo non-empty).
REQ-015 Both candidates present: FIFO head wins if FIFO full; otherwise grant alternates via last_grant bit (winner = source not granted last time).
REQ-016 Single candidate: it is granted.
REQ-017 alu_ready = 1 exactly when the ALU wins arbitration this cycle (combinational from alu_valid, FIFO state, last_grant).
REQ-018 last_grant updates only on cycles with a grant.
REQ-019 Granted entry appears on rd/wdata on the following edge (latency 1); wen=1 unless granted rd==0, then wen=0 and the entry is still consumed.
REQ-020 No grant in a cycle: wen=0 next cycle; rd/wdata hold previous values.
REQ-021 Simultaneous FIFO push and pop: both occur; occupancy unchanged; lsu_ready computed from pre-pop occupancy.
REQ-022 FIFO pointers wrap modulo LSU_DEPTH; occupancy counter range 0..LSU_DEPTH.
REQ-023 wb_count increments by 1 per cycle with registered wen=1; wraps 0xFFFFFFFF -> 0.

Reset
REQ-024 On rst: wen=0, rd=0, wdata=0, wb_count=0, FIFO empty, last_grant=LSU (ALU wins first tie).
REQ-025 rst mid-operation discards FIFO contents and any pending grant; no write is issued in the cycle after rst deasserts.
REQ-026 During rst, alu_ready=0 and lsu_ready=0.

Configuration
REQ-027 Macro WB_BYPASS_EN: when defined, adds inputs byp_rs1, byp_rs2 (ADDR_WIDTH) and outputs byp_hit1, byp_hit2 (1), byp_data (DATA_WIDTH, = wdata); hitN = wen && rd==byp_rsN && rd!=0.
REQ-028 Without WB_BYPASS_EN those ports do not exist and function is otherwise identical.

Structure
REQ-029 Shared package holds the source-select enum (SRC_ALU, SRC_LSU) and default width constants.
REQ-030 FIFO is a sub-module wb_fifo (push/pop, full/empty, count); arbiter and output register stay in wb_arbiter.

Verification
REQ-031 ALU only: alu_valid, rd=3, data=0x11 -> next cycle wen=1, rd=3, wdata=0x11, wb_count=1.
REQ-032 rd=0 from ALU, data=0xFF -> entry consumed, wen=0, wb_count unchanged.
REQ-033 Both valid every cycle, FIFO not full -> grants alternate ALU, LSU, ALU, ... starting with ALU after reset.
REQ-034 3 LSU pushes back-to-back (rd 1,2,3) with ALU saturating -> lsu_ready=0 when 2 held; FIFO head wins when full; writes in order 1,2,3 with none lost.
REQ-035 rst asserted with 2 FIFO entries pending -> after deassert, wen=0, FIFO empty, wb_count=0.
REQ-036 WB_BYPASS_EN: write rd=5 data=0xAB, byp_rs1=5, byp_rs2=0 -> byp_hit1=1, byp_hit2=0, byp_data=0xAB.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter: default widths,
// the source-select encoding and small helpers used by the top level.
package wb_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LSU_DEPTH  = 2;

  // Which producer owns the register-file write port in a given cycle.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  // Committed-write counter step; wraps naturally at 32 bits.
  function automatic logic [31:0] wb_count_next(input logic [31:0] cur);
    return cur + 32'd1;
  endfunction

  // The source that must win a tie when the FIFO is not full.
  function automatic src_e other_src(input src_e last);
    src_e res;
    if (last == SRC_ALU) begin
      res = SRC_LSU;
    end else begin
      res = SRC_ALU;
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering load results until they win the
// write port. DEPTH must be a power of two (pointers wrap by overflow).
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Never write into a full buffer or read from an empty one.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == {(PW+1){1'b0}});
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  // Storage array; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together keep count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {(PW+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and buffered load results onto
// a single registered register-file write port.
// Optional feature macro: WB_BYPASS_EN adds a forwarding compare port.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LSU_DEPTH  = DEF_LSU_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0] wdata,
`ifdef WB_BYPASS_EN
  input  logic [ADDR_WIDTH-1:0] byp_rs1,
  input  logic [ADDR_WIDTH-1:0] byp_rs2,
  output logic                  byp_hit1,
  output logic                  byp_hit2,
  output logic [DATA_WIDTH-1:0] byp_data,
`endif
  output logic [31:0]           wb_count
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(LSU_DEPTH) + 1;

  logic [EW-1:0]         w_fifo_head;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CW-1:0]         w_fifo_count;
  logic                  w_lsu_push;
  logic                  w_lsu_pop;
  logic                  w_grant;
  src_e                  w_sel;
  logic [ADDR_WIDTH-1:0] w_win_rd;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic [ADDR_WIDTH-1:0] w_head_rd;
  logic [DATA_WIDTH-1:0] w_head_data;

  src_e                  r_last_grant;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [31:0]           r_wb_count;

  // Readiness is withheld during reset so nothing is accepted then.
  assign lsu_ready  = !rst && !w_fifo_full;
  assign w_lsu_push = lsu_valid && lsu_ready;
  assign w_lsu_pop  = w_grant && (w_sel == SRC_LSU);
  assign alu_ready  = w_grant && (w_sel == SRC_ALU);

  assign w_head_rd   = w_fifo_head[EW-1:DATA_WIDTH];
  assign w_head_data = w_fifo_head[DATA_WIDTH-1:0];

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (LSU_DEPTH)
  ) u_lsu_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_lsu_push),
    .i_pop   (w_lsu_pop),
    .i_data  ({lsu_rd, lsu_data}),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Pick this cycle's winner: a full FIFO forces the load path, otherwise
  // ties alternate away from whichever source was granted last.
  always_comb begin
    w_grant = 1'b0;
    w_sel   = SRC_ALU;
    if (rst) begin
      w_grant = 1'b0;
    end else if (alu_valid && !w_fifo_empty) begin
      w_grant = 1'b1;
      if (w_fifo_full) begin
        w_sel = SRC_LSU;
      end else begin
        w_sel = other_src(r_last_grant);
      end
    end else if (alu_valid) begin
      w_grant = 1'b1;
      w_sel   = SRC_ALU;
    end else if (!w_fifo_empty) begin
      w_grant = 1'b1;
      w_sel   = SRC_LSU;
    end else begin
      w_grant = 1'b0;
    end
  end

  // Route the winning entry toward the output register.
  always_comb begin
    w_win_rd   = alu_rd;
    w_win_data = alu_data;
    if (w_sel == SRC_LSU) begin
      w_win_rd   = w_head_rd;
      w_win_data = w_head_data;
    end else begin
      w_win_rd   = alu_rd;
      w_win_data = alu_data;
    end
  end

  // Remember the last granted source; idle cycles leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= SRC_LSU;
    end else if (w_grant) begin
      r_last_grant <= w_sel;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  // Register the write port; writes to index 0 are consumed silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen      <= 1'b0;
      r_rd       <= {ADDR_WIDTH{1'b0}};
      r_wdata    <= {DATA_WIDTH{1'b0}};
      r_wb_count <= 32'd0;
    end else if (w_grant) begin
      r_rd    <= w_win_rd;
      r_wdata <= w_win_data;
      if (w_win_rd != {ADDR_WIDTH{1'b0}}) begin
        r_wen      <= 1'b1;
        r_wb_count <= wb_count_next(r_wb_count);
      end else begin
        r_wen      <= 1'b0;
        r_wb_count <= r_wb_count;
      end
    end else begin
      r_wen      <= 1'b0;
      r_wb_count <= r_wb_count;
    end
  end

  assign wen      = r_wen;
  assign rd       = r_rd;
  assign wdata    = r_wdata;
  assign wb_count = r_wb_count;

`ifdef WB_BYPASS_EN
  // Forward the value being written this cycle to matching readers.
  assign byp_hit1 = r_wen && (r_rd == byp_rs1) && (r_rd != {ADDR_WIDTH{1'b0}});
  assign byp_hit2 = r_wen && (r_rd == byp_rs2) && (r_rd != {ADDR_WIDTH{1'b0}});
  assign byp_data = r_wdata;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_wb_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, alu_ready, lsu_valid, lsu_ready, wen;
  logic [AW-1:0] alu_rd, lsu_rd, rd;
  logic [DW-1:0] alu_data, lsu_data, wdata;
  logic [31:0]   wb_count;
`ifdef WB_BYPASS_EN
  logic [AW-1:0] byp_rs1, byp_rs2;
  logic          byp_hit1, byp_hit2;
  logic [DW-1:0] byp_data;
`endif

  wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LSU_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wen(wen), .rd(rd), .wdata(wdata),
`ifdef WB_BYPASS_EN
    .byp_rs1(byp_rs1), .byp_rs2(byp_rs2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data(byp_data),
`endif
    .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, av, lv;
    logic [4:0]  ard, lrd;
    logic [31:0] ad, ld;
    logic        e_ardy, e_lrdy, e_wen;
    logic [4:0]  e_rd;
    logic [31:0] e_wd, e_cnt;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state: pending loads in arrival order, plus outputs.
  logic [36:0] mq[$];
  bit          m_last_alu;
  logic        m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_wd, m_cnt;
  logic        s_ardy, s_lrdy;
  logic [4:0]  wr_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // 0 = nobody, 1 = ALU, 2 = load buffer head.
  function automatic int winner(input logic r, input logic av);
    if (r) return 0;
    if (av && mq.size() == 0) return 1;
    if (!av && mq.size() > 0) return 2;
    if (!av) return 0;
    if (mq.size() == DEPTH) return 2;
    return m_last_alu ? 2 : 1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last_alu = 1'b0;
    m_wen = 1'b0; m_rd = 5'd0; m_wd = 32'd0; m_cnt = 32'd0;
  endtask

  task automatic apply(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    int w;
    bit can_push;
    logic [36:0] ent;
    @(negedge clk);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    #1;
    w = winner(r, av);
    can_push = !r && (mq.size() < DEPTH);
    s_ardy = alu_ready; s_lrdy = lsu_ready;
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, (w == 1)});
    chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, can_push});
    if (r) begin
      model_reset();
    end else begin
      if (w == 1) begin
        m_rd = ard; m_wd = ad; m_last_alu = 1'b1;
      end else if (w == 2) begin
        ent = mq.pop_front();
        m_rd = ent[36:32]; m_wd = ent[31:0]; m_last_alu = 1'b0;
      end
      m_wen = (w != 0) && (m_rd != 5'd0);
      if (m_wen) m_cnt = m_cnt + 32'd1;
      if (lv && can_push) mq.push_back({lrd, ld});
    end
    @(posedge clk);
    #1;
    chk("wen", {31'd0, wen}, {31'd0, m_wen});
    chk("rd", {27'd0, rd}, {27'd0, m_rd});
    chk("wdata", wdata, m_wd);
    chk("wb_count", wb_count, m_cnt);
    if (wen === 1'b1) wr_log.push_back(rd);
  endtask

  function automatic vec_t mk(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              input logic ea, input logic el, input logic ew,
                              input logic [4:0] erd, input logic [31:0] ewd, input logic [31:0] ec);
    vec_t v;
    v.r = r; v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.e_ardy = ea; v.e_lrdy = el; v.e_wen = ew; v.e_rd = erd; v.e_wd = ewd; v.e_cnt = ec;
    return v;
  endfunction

  vec_t tbl[13];
  int   k;

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
`ifdef WB_BYPASS_EN
    byp_rs1 = 5'd0; byp_rs2 = 5'd0;
`endif
    model_reset();

    //          r     av    ard    ad           lv    lrd    ld          ardy  lrdy  wen   rd     wdata        cnt
    tbl[0]  = mk(1'b1, 1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 5'd0,  32'h0,  32'd0);
    tbl[1]  = mk(1'b0, 1'b1, 5'd3,  32'h11,     1'b0, 5'd0,  32'h0,      1'b1, 1'b1, 1'b1, 5'd3,  32'h11, 32'd1);
    tbl[2]  = mk(1'b0, 1'b1, 5'd0,  32'hFF,     1'b0, 5'd0,  32'h0,      1'b1, 1'b1, 1'b0, 5'd0,  32'hFF, 32'd1);
    tbl[3]  = mk(1'b0, 1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b1, 1'b0, 5'd0,  32'hFF, 32'd1);
    tbl[4]  = mk(1'b1, 1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 5'd0,  32'h0,  32'd0);
    tbl[5]  = mk(1'b0, 1'b1, 5'd4,  32'h40,     1'b1, 5'd5,  32'h50,     1'b1, 1'b1, 1'b1, 5'd4,  32'h40, 32'd1);
    tbl[6]  = mk(1'b0, 1'b1, 5'd6,  32'h60,     1'b1, 5'd7,  32'h70,     1'b0, 1'b1, 1'b1, 5'd5,  32'h50, 32'd2);
    tbl[7]  = mk(1'b0, 1'b1, 5'd6,  32'h60,     1'b1, 5'd8,  32'h80,     1'b1, 1'b1, 1'b1, 5'd6,  32'h60, 32'd3);
    tbl[8]  = mk(1'b0, 1'b1, 5'd9,  32'h90,     1'b1, 5'd10, 32'hA0,     1'b0, 1'b0, 1'b1, 5'd7,  32'h70, 32'd4);
    tbl[9]  = mk(1'b0, 1'b1, 5'd9,  32'h90,     1'b1, 5'd10, 32'hA0,     1'b1, 1'b1, 1'b1, 5'd9,  32'h90, 32'd5);
    tbl[10] = mk(1'b0, 1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b1, 5'd8,  32'h80, 32'd6);
    tbl[11] = mk(1'b0, 1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b1, 1'b1, 5'd10, 32'hA0, 32'd7);
    tbl[12] = mk(1'b0, 1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b1, 1'b0, 5'd10, 32'hA0, 32'd7);

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].r, tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].lv, tbl[i].lrd, tbl[i].ld);
      chk($sformatf("tbl%0d_alu_ready", i), {31'd0, s_ardy}, {31'd0, tbl[i].e_ardy});
      chk($sformatf("tbl%0d_lsu_ready", i), {31'd0, s_lrdy}, {31'd0, tbl[i].e_lrdy});
      chk($sformatf("tbl%0d_wen", i), {31'd0, wen}, {31'd0, tbl[i].e_wen});
      chk($sformatf("tbl%0d_rd", i), {27'd0, rd}, {27'd0, tbl[i].e_rd});
      chk($sformatf("tbl%0d_wdata", i), wdata, tbl[i].e_wd);
      chk($sformatf("tbl%0d_wb_count", i), wb_count, tbl[i].e_cnt);
    end

    // Reset with two loads pending: everything is discarded.
    apply(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    apply(1'b0, 1'b1, 5'd4, 32'h40, 1'b1, 5'd5, 32'h50);
    apply(1'b0, 1'b1, 5'd6, 32'h60, 1'b1, 5'd7, 32'h70);
    apply(1'b0, 1'b1, 5'd6, 32'h60, 1'b1, 5'd8, 32'h80);
    apply(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("rstmid_wen", {31'd0, wen}, 32'd0);
    chk("rstmid_count", wb_count, 32'd0);
    apply(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("rstmid_empty_lsu_ready", {31'd0, s_lrdy}, 32'd1);
    chk("rstmid_no_stale_write", {31'd0, wen}, 32'd0);
    chk("rstmid_count2", wb_count, 32'd0);

    // Three loads pushed back-to-back against a saturating ALU stream.
    apply(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    wr_log.delete();
    k = 1;
    for (int c = 0; c < 16; c++) begin
      apply(1'b0, 1'b1, 5'd20, 32'h20, (k <= 3), k[4:0], 32'h300 + k);
      if (s_lrdy && k <= 3) k++;
    end
    for (int c = 0; c < 4; c++) apply(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    begin
      int got[$];
      foreach (wr_log[j]) if (wr_log[j] >= 5'd1 && wr_log[j] <= 5'd3) got.push_back(int'(wr_log[j]));
      chk("lsu_order_count", got.size(), 32'd3);
      for (int j = 0; j < 3; j++)
        chk($sformatf("lsu_order_%0d", j), (got.size() > j) ? got[j] : 32'hDEAD, j + 1);
    end

`ifdef WB_BYPASS_EN
    apply(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    apply(1'b0, 1'b1, 5'd5, 32'hAB, 1'b0, 5'd0, 32'h0);
    byp_rs1 = 5'd5; byp_rs2 = 5'd0;
    #1;
    chk("byp_hit1", {31'd0, byp_hit1}, 32'd1);
    chk("byp_hit2", {31'd0, byp_hit2}, 32'd0);
    chk("byp_data", byp_data, 32'hAB);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
